// File: rtl/riscv_nn_rf_wb_arbiter.sv
// Purpose : merges ALU, MULT/FPU and LSU results onto the two register-file write ports.
// Latency : ALU -> port A in 1 cycle; MULT/LSU through an empty FIFO -> port in 2 cycles.
// Backpr. : ALU is never stalled; MULT/LSU use valid/ready, ready drops when the FIFO is full.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid_i/_waddr_i/_wdata_i  single-cycle ALU result (always accepted)
//   mul_valid_i/_ready_o/...       MULT/FPU result into a FIFO_DEPTH-entry FIFO
//   lsu_valid_i/_ready_o/...       LSU load data into a FIFO_DEPTH-entry FIFO
//   we_a_o/waddr_a_o/wdata_a_o     registered write port A
//   we_b_o/waddr_b_o/wdata_b_o     registered write port B
//   wb_pending_o                   something buffered or being written this cycle
module riscv_nn_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  mul_valid_i,
    output logic                  mul_ready_o,
    input  logic [ADDR_WIDTH-1:0] mul_waddr_i,
    input  logic [DATA_WIDTH-1:0] mul_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  wb_pending_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // FIFO storage and control
    logic [ADDR_WIDTH-1:0] r_mul_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mul_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_lsu_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_lsu_data [FIFO_DEPTH];
    logic [PW-1:0]         r_mul_wr, r_mul_rd, r_lsu_wr, r_lsu_rd;
    logic [CW-1:0]         r_mul_cnt, r_lsu_cnt;

    // Registered write ports
    logic                  r_we_a, r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_a, r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_a, r_wdata_b;

    logic                  w_mul_push, w_lsu_push, w_mul_pop, w_lsu_pop;
    logic                  w_alu_c, w_lsu_c, w_mul_c;
    logic [ADDR_WIDTH-1:0] w_lsu_haddr, w_mul_haddr;
    logic [DATA_WIDTH-1:0] w_lsu_hdata, w_mul_hdata;
    logic                  w_sel_a_vld, w_sel_b_vld;
    logic [ADDR_WIDTH-1:0] w_sel_a_addr, w_sel_b_addr;
    logic [DATA_WIDTH-1:0] w_sel_a_data, w_sel_b_data;

    // Ready comes from the registered count only, so a full FIFO stays not-ready
    // even when its head pops in the same cycle.
    assign mul_ready_o = ~rst & (r_mul_cnt < CW'(FIFO_DEPTH));
    assign lsu_ready_o = ~rst & (r_lsu_cnt < CW'(FIFO_DEPTH));

    // x0 writes complete the handshake but are never stored.
    assign w_mul_push = mul_valid_i & mul_ready_o & (mul_waddr_i != '0);
    assign w_lsu_push = lsu_valid_i & lsu_ready_o & (lsu_waddr_i != '0);

    assign w_alu_c     = alu_valid_i & (alu_waddr_i != '0);
    assign w_lsu_c     = (r_lsu_cnt != '0);
    assign w_mul_c     = (r_mul_cnt != '0);
    assign w_lsu_haddr = r_lsu_addr[r_lsu_rd];
    assign w_lsu_hdata = r_lsu_data[r_lsu_rd];
    assign w_mul_haddr = r_mul_addr[r_mul_rd];
    assign w_mul_hdata = r_mul_data[r_mul_rd];

    // Priority ALU > LSU > MULT. Port A gets the top candidate, port B the next one
    // unless it targets the same register, in which case B idles and the loser waits.
    always_comb begin
        w_sel_a_vld  = 1'b0;
        w_sel_a_addr = '0;
        w_sel_a_data = '0;
        w_sel_b_vld  = 1'b0;
        w_sel_b_addr = '0;
        w_sel_b_data = '0;
        w_lsu_pop    = 1'b0;
        w_mul_pop    = 1'b0;
        if (w_alu_c) begin
            w_sel_a_vld  = 1'b1;
            w_sel_a_addr = alu_waddr_i;
            w_sel_a_data = alu_wdata_i;
            if (w_lsu_c) begin
                if (w_lsu_haddr != alu_waddr_i) begin
                    w_sel_b_vld  = 1'b1;
                    w_sel_b_addr = w_lsu_haddr;
                    w_sel_b_data = w_lsu_hdata;
                    w_lsu_pop    = 1'b1;
                end
            end else if (w_mul_c) begin
                if (w_mul_haddr != alu_waddr_i) begin
                    w_sel_b_vld  = 1'b1;
                    w_sel_b_addr = w_mul_haddr;
                    w_sel_b_data = w_mul_hdata;
                    w_mul_pop    = 1'b1;
                end
            end
        end else if (w_lsu_c) begin
            w_sel_a_vld  = 1'b1;
            w_sel_a_addr = w_lsu_haddr;
            w_sel_a_data = w_lsu_hdata;
            w_lsu_pop    = 1'b1;
            if (w_mul_c && (w_mul_haddr != w_lsu_haddr)) begin
                w_sel_b_vld  = 1'b1;
                w_sel_b_addr = w_mul_haddr;
                w_sel_b_data = w_mul_hdata;
                w_mul_pop    = 1'b1;
            end
        end else if (w_mul_c) begin
            w_sel_a_vld  = 1'b1;
            w_sel_a_addr = w_mul_haddr;
            w_sel_a_data = w_mul_hdata;
            w_mul_pop    = 1'b1;
        end
    end

    // FIFO payload needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (w_mul_push) begin
            r_mul_addr[r_mul_wr] <= mul_waddr_i;
            r_mul_data[r_mul_wr] <= mul_wdata_i;
        end
        if (w_lsu_push) begin
            r_lsu_addr[r_lsu_wr] <= lsu_waddr_i;
            r_lsu_data[r_lsu_wr] <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_wr  <= '0;
            r_mul_rd  <= '0;
            r_mul_cnt <= '0;
            r_lsu_wr  <= '0;
            r_lsu_rd  <= '0;
            r_lsu_cnt <= '0;
            r_we_a    <= 1'b0;
            r_waddr_a <= '0;
            r_wdata_a <= '0;
            r_we_b    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_mul_push) r_mul_wr <= r_mul_wr + PW'(1);
            if (w_mul_pop)  r_mul_rd <= r_mul_rd + PW'(1);
            if (w_lsu_push) r_lsu_wr <= r_lsu_wr + PW'(1);
            if (w_lsu_pop)  r_lsu_rd <= r_lsu_rd + PW'(1);
            if (w_mul_push && !w_mul_pop)      r_mul_cnt <= r_mul_cnt + CW'(1);
            else if (!w_mul_push && w_mul_pop) r_mul_cnt <= r_mul_cnt - CW'(1);
            if (w_lsu_push && !w_lsu_pop)      r_lsu_cnt <= r_lsu_cnt + CW'(1);
            else if (!w_lsu_push && w_lsu_pop) r_lsu_cnt <= r_lsu_cnt - CW'(1);
            // Address/data hold their last value while the enable is low.
            r_we_a <= w_sel_a_vld;
            r_we_b <= w_sel_b_vld;
            if (w_sel_a_vld) begin
                r_waddr_a <= w_sel_a_addr;
                r_wdata_a <= w_sel_a_data;
            end
            if (w_sel_b_vld) begin
                r_waddr_b <= w_sel_b_addr;
                r_wdata_b <= w_sel_b_data;
            end
        end
    end

    assign we_a_o       = r_we_a;
    assign waddr_a_o    = r_waddr_a;
    assign wdata_a_o    = r_wdata_a;
    assign we_b_o       = r_we_b;
    assign waddr_b_o    = r_waddr_b;
    assign wdata_b_o    = r_wdata_b;
    assign wb_pending_o = (r_mul_cnt != '0) | (r_lsu_cnt != '0) | r_we_a | r_we_b;

endmodule

// File: tb/tb_riscv_nn_rf_wb_arbiter.sv
// Bench for riscv_nn_rf_wb_arbiter: directed scenario tasks plus a per-source
// scoreboard that checks every issued write against that source's accepted order.
module tb_riscv_nn_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_waddr_i = '0;
    logic [31:0] alu_wdata_i = '0;
    logic        mul_valid_i = 1'b0;
    logic        mul_ready_o;
    logic [4:0]  mul_waddr_i = '0;
    logic [31:0] mul_wdata_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        we_a_o, we_b_o, wb_pending_o;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t alu_q[$];
    wr_t lsu_q[$];
    wr_t mul_q[$];
    bit  mon_hit;

    riscv_nn_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o),
        .mul_waddr_i(mul_waddr_i), .mul_wdata_i(mul_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
        .wb_pending_o(wb_pending_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consume the head of whichever source queue matches the observed write.
    task automatic sb_take(input logic [4:0] a, input logic [31:0] d, output bit hit);
        hit = 1'b0;
        if (alu_q.size() > 0 && alu_q[0].a === a && alu_q[0].d === d) begin
            void'(alu_q.pop_front()); hit = 1'b1;
        end else if (lsu_q.size() > 0 && lsu_q[0].a === a && lsu_q[0].d === d) begin
            void'(lsu_q.pop_front()); hit = 1'b1;
        end else if (mul_q.size() > 0 && mul_q[0].a === a && mul_q[0].d === d) begin
            void'(mul_q.pop_front()); hit = 1'b1;
        end
    endtask

    // Mid-cycle monitor: check issued writes, then record this cycle's accepted results.
    always @(negedge clk) begin
        if (we_a_o === 1'b1) begin
            checks++;
            sb_take(waddr_a_o, wdata_a_o, mon_hit);
            if (!mon_hit || waddr_a_o === 5'd0) begin
                errors++;
                $display("FAIL sb_port_a: got x%0d=%h, required next in-order result of some source (queued alu %0d lsu %0d mul %0d)",
                         waddr_a_o, wdata_a_o, alu_q.size(), lsu_q.size(), mul_q.size());
            end
        end
        if (we_b_o === 1'b1) begin
            checks++;
            sb_take(waddr_b_o, wdata_b_o, mon_hit);
            if (!mon_hit || waddr_b_o === 5'd0) begin
                errors++;
                $display("FAIL sb_port_b: got x%0d=%h, required next in-order result of some source (queued alu %0d lsu %0d mul %0d)",
                         waddr_b_o, wdata_b_o, alu_q.size(), lsu_q.size(), mul_q.size());
            end
        end
        if (we_a_o === 1'b1 && we_b_o === 1'b1) begin
            checks++;
            if (waddr_a_o === waddr_b_o) begin
                errors++;
                $display("FAIL same_addr: both ports write x%0d, required distinct", waddr_a_o);
            end
        end
        if (rst) begin
            alu_q.delete(); lsu_q.delete(); mul_q.delete();
        end else begin
            if (alu_valid_i && alu_waddr_i != 5'd0) alu_q.push_back({alu_waddr_i, alu_wdata_i});
            if (lsu_valid_i && lsu_ready_o && lsu_waddr_i != 5'd0) lsu_q.push_back({lsu_waddr_i, lsu_wdata_i});
            if (mul_valid_i && mul_ready_o && mul_waddr_i != 5'd0) mul_q.push_back({mul_waddr_i, mul_wdata_i});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        mul_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid_i = 1'b1; alu_waddr_i = 5'd1; alu_wdata_i = 32'h1111_1111;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h2222_2222;
        mul_valid_i = 1'b1; mul_waddr_i = 5'd3; mul_wdata_i = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (we_a_o !== 1'b0) begin errors++; $display("FAIL rst_we_a: got %b required 0", we_a_o); end
            checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL rst_we_b: got %b required 0", we_b_o); end
            checks++; if (mul_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mul_ready: got %b required 0", mul_ready_o); end
            checks++; if (lsu_ready_o !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %b required 0", lsu_ready_o); end
            checks++; if (wb_pending_o !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b required 0", wb_pending_o); end
        end
        idle();
        rst = 1'b0;
        #1;
        checks++; if (mul_ready_o !== 1'b1) begin errors++; $display("FAIL rel_mul_ready: got %b required 1", mul_ready_o); end
        checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL rel_lsu_ready: got %b required 1", lsu_ready_o); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++; $display("FAIL rel_no_we: got %b%b required 00", we_a_o, we_b_o); end
            checks++; if (waddr_a_o !== 5'd0 || wdata_a_o !== 32'd0) begin errors++; $display("FAIL rel_port_a_zero: got x%0d=%h required x0=0", waddr_a_o, wdata_a_o); end
        end
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'hDEAD_BEEF;
        tick();
        idle();
        checks++; if (we_a_o !== 1'b1) begin errors++; $display("FAIL alu_we_a: got %b required 1", we_a_o); end
        checks++; if (waddr_a_o !== 5'd5) begin errors++; $display("FAIL alu_waddr_a: got %0d required 5", waddr_a_o); end
        checks++; if (wdata_a_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_wdata_a: got %h required deadbeef", wdata_a_o); end
        checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL alu_we_b: got %b required 0", we_b_o); end
        tick();
        checks++; if (we_a_o !== 1'b0) begin errors++; $display("FAIL alu_one_shot: got %b required 0", we_a_o); end
        checks++; if (waddr_a_o !== 5'd5 || wdata_a_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_hold: got x%0d=%h required x5=deadbeef", waddr_a_o, wdata_a_o); end
    endtask

    task automatic test_triple_issue();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'hA000_0003;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'hB000_0007;
        mul_valid_i = 1'b1; mul_waddr_i = 5'd9; mul_wdata_i = 32'hC000_0009;
        #1;
        checks++; if (lsu_ready_o !== 1'b1 || mul_ready_o !== 1'b1) begin errors++; $display("FAIL tri_accept: got lsu %b mul %b required 11", lsu_ready_o, mul_ready_o); end
        tick();
        idle();
        // a second ALU result keeps port A busy so the LSU head goes to port B
        alu_valid_i = 1'b1; alu_waddr_i = 5'd11; alu_wdata_i = 32'hA000_000B;
        checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd3 || we_b_o !== 1'b0) begin errors++; $display("FAIL tri_c1: got a=%b x%0d b=%b required a=1 x3 b=0", we_a_o, waddr_a_o, we_b_o); end
        tick();
        idle();
        checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd11) begin errors++; $display("FAIL tri_c2_a: got %b x%0d required 1 x11", we_a_o, waddr_a_o); end
        checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd7 || wdata_b_o !== 32'hB000_0007) begin errors++; $display("FAIL tri_c2_b: got %b x%0d=%h required 1 x7=b0000007", we_b_o, waddr_b_o, wdata_b_o); end
        tick();
        checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd9 || wdata_a_o !== 32'hC000_0009 || we_b_o !== 1'b0) begin errors++; $display("FAIL tri_c3: got a=%b x%0d=%h b=%b required a=1 x9=c0000009 b=0", we_a_o, waddr_a_o, wdata_a_o, we_b_o); end
        tick();
        checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0 || wb_pending_o !== 1'b0) begin errors++; $display("FAIL tri_drained: got %b%b pend %b required 00 0", we_a_o, we_b_o, wb_pending_o); end
    endtask

    task automatic test_conflict();
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4; lsu_wdata_i = 32'hB000_0004;
        tick();
        idle();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd4; alu_wdata_i = 32'hA000_0004;
        tick();
        idle();
        checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd4 || wdata_a_o !== 32'hA000_0004) begin errors++; $display("FAIL conf_alu: got %b x%0d=%h required 1 x4=a0000004", we_a_o, waddr_a_o, wdata_a_o); end
        checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL conf_b_idle: got %b required 0", we_b_o); end
        tick();
        checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd4 || wdata_a_o !== 32'hB000_0004) begin errors++; $display("FAIL conf_lsu: got %b x%0d=%h required 1 x4=b0000004", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
    endtask

    task automatic test_backpressure();
        int idx;
        int third_c;
        bit acc;
        idx = 0;
        third_c = -1;
        for (int c = 0; c < 30; c++) begin
            alu_valid_i = (c < 10); alu_waddr_i = 5'(10 + c); alu_wdata_i = 32'hA100_0000 + 32'(c);
            lsu_valid_i = (c < 6);  lsu_waddr_i = 5'(20 + c); lsu_wdata_i = 32'hB100_0000 + 32'(c);
            mul_valid_i = (idx < 3); mul_waddr_i = 5'(26 + idx); mul_wdata_i = 32'hC100_0000 + 32'(idx);
            #1;
            if (c == 2 || c == 4) begin
                checks++; if (mul_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_c%0d: got mul_ready %b required 0", c, mul_ready_o); end
            end
            acc = mul_valid_i && mul_ready_o;
            if (acc && idx == 2) third_c = c;
            tick();
            if (acc) idx++;
        end
        idle();
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_all_pushed: got %0d pushes required 3", idx); end
        checks++; if (third_c !== 8) begin errors++; $display("FAIL bp_third_cycle: got cycle %0d required 8", third_c); end
    endtask

    task automatic test_x0_and_midreset();
        alu_valid_i = 1'b1; alu_waddr_i = 5'd0; alu_wdata_i = 32'h0BAD_0000;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'h0BAD_0001;
        #1;
        checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b required 1", lsu_ready_o); end
        tick();
        idle();
        checks++; if (wb_pending_o !== 1'b0 || lsu_ready_o !== 1'b1) begin errors++; $display("FAIL x0_not_stored: got pend %b ready %b required 0 1", wb_pending_o, lsu_ready_o); end
        tick();
        checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++; $display("FAIL x0_no_we: got %b%b required 00", we_a_o, we_b_o); end

        alu_valid_i = 1'b1; alu_waddr_i = 5'd14; alu_wdata_i = 32'hA000_000E;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'hB000_000C;
        mul_valid_i = 1'b1; mul_waddr_i = 5'd13; mul_wdata_i = 32'hC000_000D;
        tick();
        idle();
        checks++; if (wb_pending_o !== 1'b1 || we_a_o !== 1'b1) begin errors++; $display("FAIL mr_buffered: got pend %b we_a %b required 1 1", wb_pending_o, we_a_o); end
        rst = 1'b1;
        tick();
        checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0 || wb_pending_o !== 1'b0) begin errors++; $display("FAIL mr_flushed: got %b%b pend %b required 00 0", we_a_o, we_b_o, wb_pending_o); end
        checks++; if (mul_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b%b required 00", mul_ready_o, lsu_ready_o); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0 || wb_pending_o !== 1'b0) begin errors++; $display("FAIL mr_no_write: got %b%b pend %b required 00 0", we_a_o, we_b_o, wb_pending_o); end
        end
    endtask

    task automatic test_drained();
        idle();
        repeat (3) tick();
        checks++; if (alu_q.size() != 0 || lsu_q.size() != 0 || mul_q.size() != 0) begin errors++; $display("FAIL sb_empty: got alu %0d lsu %0d mul %0d outstanding required 0", alu_q.size(), lsu_q.size(), mul_q.size()); end
        checks++; if (wb_pending_o !== 1'b0) begin errors++; $display("FAIL end_pending: got %b required 0", wb_pending_o); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_triple_issue();
        test_conflict();
        test_backpressure();
        test_drained();
        test_x0_and_midreset();
        test_drained();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
